// File: rtl/proc_mem_resp_pkg.sv
// Shared types for proc_mem_resp: controller state encoding, data-port
// request type encodings and a byte-insertion helper for the loader.
package proc_mem_resp_pkg;

  // Controller state: LOAD streams the program in, RUN serves the processor.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // dmemreq_type encodings.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int unsigned WORD_W = 32;

  // Return word with byte b placed in byte lane idx (lane 0 = bits 7:0).
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                   input logic [7:0]        b,
                                                   input logic [1:0]        idx);
    logic [WORD_W-1:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/proc_mem_resp_loader.sv
// Program-loader byte assembler: packs an accepted byte stream little-endian
// into 32-bit words and emits one write strobe per completed (or final
// partial) word at an auto-incrementing, wrapping word pointer.
//
// Handshake: a byte is consumed on a posedge where load_en & load_val are
// both high; load_en is the parent's ready, so there is never a stall.
module proc_mem_resp_loader
  import proc_mem_resp_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_val,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [WORD_W-1:0] wr_data,
  output logic              last_acc,
  output logic              ptr_wrap
);

  logic [1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [23:0]      asm_q, asm_d;

  logic              accept;
  logic [WORD_W-1:0] word_c;

  // Next-state for counter, pointer and assembly register, plus write strobe.
  always_comb begin
    accept   = load_en & load_val;
    // Bytes above the current lane are always zero in asm_q, so a final
    // partial word comes out zero-filled for free.
    word_c   = place_byte({8'h00, asm_q}, load_byte, cnt_q);
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    asm_d    = asm_q;
    wr_en    = 1'b0;
    if (accept) begin
      if ((cnt_q == 2'd3) || load_last) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        cnt_d = 2'd0;
        asm_d = 24'h0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        asm_d = word_c[23:0];
      end
    end
    wr_idx   = ptr_q;
    wr_data  = word_c;
    last_acc = accept & load_last;
    ptr_wrap = wr_en & (ptr_q == {IDX_W{1'b1}});
  end

  // Assembler registers; reset discards any partial word and rewinds to word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      ptr_q <= '0;
      asm_q <= 24'h0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/proc_mem_resp.sv
// Processor instruction/data memory with a built-in program loader.
// After reset the block sits in LOAD, holding the processor in reset while a
// byte stream fills memory from word 0; once the last byte is taken it moves
// to RUN and serves combinational instruction fetches and data reads plus
// posedge data writes. Memory is never cleared.
// Optional build macro PROC_MEM_RESP_ERR_EN adds a sticky err output for
// out-of-range RUN addresses and loader pointer wrap.
module proc_mem_resp
  import proc_mem_resp_pkg::*;
#(
  parameter int NUM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic        load_val,
  output logic        load_rdy,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        proc_rst,
  output logic        loaded
`ifdef PROC_MEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  state_e state_q, state_d;

  logic [WORD_W-1:0] mem_q [NUM_WORDS];

  logic              run;
  logic [IDX_W-1:0]  imem_idx;
  logic [IDX_W-1:0]  dmem_idx;

  logic              ld_wr_en;
  logic [IDX_W-1:0]  ld_wr_idx;
  logic [WORD_W-1:0] ld_wr_data;
  logic              ld_last_acc;
  logic              ld_ptr_wrap;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [WORD_W-1:0] mem_wdata;

  // Byte-stream assembler; only runs while in LOAD.
  proc_mem_resp_loader #(
    .IDX_W (IDX_W)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_rdy),
    .load_val  (load_val),
    .load_byte (load_byte),
    .load_last (load_last),
    .wr_en     (ld_wr_en),
    .wr_idx    (ld_wr_idx),
    .wr_data   (ld_wr_data),
    .last_acc  (ld_last_acc),
    .ptr_wrap  (ld_ptr_wrap)
  );

  // FSM next state and state-derived status outputs.
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_LOAD) && ld_last_acc) begin
      state_d = ST_RUN;
    end
    run      = (state_q == ST_RUN);
    load_rdy = (state_q == ST_LOAD);
    loaded   = run;
    proc_rst = rst | (state_q == ST_LOAD);
  end

  // FSM state register; RUN is left only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Read ports: combinational, zero unless a valid RUN-state request.
  // Reads see the array before any write on the same edge (old data).
  always_comb begin
    imem_idx       = imemreq_addr[2 +: IDX_W];
    dmem_idx       = dmemreq_addr[2 +: IDX_W];
    imemresp_data  = '0;
    dmemresp_rdata = '0;
    if (run && imemreq_val) begin
      imemresp_data = mem_q[imem_idx];
    end
    if (run && dmemreq_val && (dmemreq_type == MEM_READ)) begin
      dmemresp_rdata = mem_q[dmem_idx];
    end
  end

  // Single write port: the loader owns it in LOAD, the processor in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = ld_wr_idx;
    mem_wdata = ld_wr_data;
    if (!rst) begin
      if (ld_wr_en) begin
        mem_we = 1'b1;
      end else if (run && dmemreq_val && (dmemreq_type == MEM_WRITE)) begin
        mem_we    = 1'b1;
        mem_widx  = dmem_idx;
        mem_wdata = dmemreq_wdata;
      end
    end
  end

  // Storage array; intentionally not reset so a reload can be partial.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

`ifdef PROC_MEM_RESP_ERR_EN
  logic err_q, err_d;
  logic imem_hi, dmem_hi;

  // Sticky error: out-of-range RUN address on either port, or loader wrap.
  always_comb begin
    imem_hi = ((imemreq_addr >> (2 + IDX_W)) != 32'h0);
    dmem_hi = ((dmemreq_addr >> (2 + IDX_W)) != 32'h0);
    err_d   = err_q | ld_ptr_wrap |
              (run & ((imemreq_val & imem_hi) | (dmemreq_val & dmem_hi)));
    err     = err_q;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // Byte offsets and out-of-range address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{imemreq_addr, dmemreq_addr, ld_ptr_wrap};

endmodule

// File: tb/tb_proc_mem_resp.sv
// Self-checking bench for proc_mem_resp (default NUM_WORDS=256).
// Define PROC_MEM_RESP_ERR_EN for both bench and RTL to cover the err port.
module tb_proc_mem_resp;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        load_val;
  logic        load_rdy;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        proc_rst;
  logic        loaded;
`ifdef PROC_MEM_RESP_ERR_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  logic [31:0] model_mem [256];
  bit          model_vld [256];

  proc_mem_resp #(
    .NUM_WORDS (256)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imemreq_val    (imemreq_val),
    .imemreq_addr   (imemreq_addr),
    .imemresp_data  (imemresp_data),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_type   (dmemreq_type),
    .dmemreq_addr   (dmemreq_addr),
    .dmemreq_wdata  (dmemreq_wdata),
    .dmemresp_rdata (dmemresp_rdata),
    .load_val       (load_val),
    .load_rdy       (load_rdy),
    .load_byte      (load_byte),
    .load_last      (load_last),
    .proc_rst       (proc_rst),
    .loaded         (loaded)
`ifdef PROC_MEM_RESP_ERR_EN
    ,
    .err            (err)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pop the next expected value from the scoreboard and compare.
  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got=%h expected=<empty scoreboard>", tag, got);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("proc_rst_in_rst", {31'b0, proc_rst}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_load_rdy", {31'b0, load_rdy}, 32'd1);
    check("rst_proc_rst", {31'b0, proc_rst}, 32'd1);
    check("rst_loaded",   {31'b0, loaded},   32'd0);
`ifdef PROC_MEM_RESP_ERR_EN
    check("rst_err",      {31'b0, err},      32'd0);
`endif
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_val  = 1'b1;
    load_byte = b;
    load_last = last;
    tick();
    load_val  = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[7:0],   1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], last);
  endtask

  task automatic expect_run(input string tag);
    @(negedge clk);
    check({tag, "_loaded"},   {31'b0, loaded},   32'd1);
    check({tag, "_proc_rst"}, {31'b0, proc_rst}, 32'd0);
    check({tag, "_load_rdy"}, {31'b0, load_rdy}, 32'd0);
    tick();
  endtask

  // Fetch and data-read the same address in one cycle.
  task automatic read_both(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    imemreq_val  = 1'b1;
    imemreq_addr = addr;
    dmemreq_val  = 1'b1;
    dmemreq_type = 1'b0;
    dmemreq_addr = addr;
    exp_q.push_back(exp);
    exp_q.push_back(exp);
    @(negedge clk);
    sb_check({tag, "_imem"}, imemresp_data);
    sb_check({tag, "_dmem"}, dmemresp_rdata);
    tick();
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
  endtask

  task automatic dmem_write(input logic [31:0] addr, input logic [31:0] data);
    dmemreq_val   = 1'b1;
    dmemreq_type  = 1'b1;
    dmemreq_addr  = addr;
    dmemreq_wdata = data;
    tick();
    dmemreq_val   = 1'b0;
    dmemreq_type  = 1'b0;
  endtask

  initial begin
    int idx;
    logic [31:0] d;
    rst = 1'b1;
    imemreq_val = 1'b0; imemreq_addr = '0;
    dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
    load_val = 1'b0; load_byte = '0; load_last = 1'b0;
    tick();

    // Single-byte program: partial word zero-filled, RUN next cycle.
    do_reset();
    send_byte(8'hAB, 1'b1);
    expect_run("one_byte");
    read_both("one_byte_mem0", 32'h0, 32'h0000_00AB);
    dmem_write(32'h40, 32'h1111_2222);
    read_both("run_wr_w16", 32'h40, 32'h1111_2222);

    // Processor accesses while loading are ignored / read as zero.
    do_reset();
    imemreq_val   = 1'b1; imemreq_addr = 32'h0;
    dmemreq_val   = 1'b1; dmemreq_type = 1'b1;
    dmemreq_addr  = 32'h40; dmemreq_wdata = 32'hBAD0_BAD0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    sb_check("load_imem_zero", imemresp_data);
    sb_check("load_dmem_zero", dmemresp_rdata);
    tick();
    imemreq_val = 1'b0; dmemreq_val = 1'b0; dmemreq_type = 1'b0;
    read_both("load_read_zero", 32'h40, 32'h0);

    // Two-word program.
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    @(negedge clk);
    check("mid_load_loaded", {31'b0, loaded}, 32'd0);
    tick();
    send_byte(8'h00, 1'b1);
    expect_run("two_word");
    read_both("prog_mem0", 32'h0, 32'h0000_0013);
    read_both("prog_mem1", 32'h4, 32'h0010_0093);
    read_both("load_wr_ignored", 32'h40, 32'h1111_2222);

    // Same-cycle write/fetch returns old data; new data on the next cycle.
    dmem_write(32'h8, 32'h1234_5678);
    imemreq_val   = 1'b1; imemreq_addr = 32'h8;
    dmemreq_val   = 1'b1; dmemreq_type = 1'b1;
    dmemreq_addr  = 32'h8; dmemreq_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h0);
    @(negedge clk);
    sb_check("wr_same_cycle_imem_old", imemresp_data);
    sb_check("wr_cycle_dmem_rdata", dmemresp_rdata);
    tick();
    imemreq_val = 1'b0; dmemreq_val = 1'b0; dmemreq_type = 1'b0;
    read_both("wr_next_cycle", 32'h8, 32'hDEAD_BEEF);
    read_both("byte_offset_ignored", 32'hB, 32'hDEAD_BEEF);
`ifndef PROC_MEM_RESP_ERR_EN
    read_both("upper_bits_ignored", 32'h0000_1008, 32'hDEAD_BEEF);
`endif

    // Random processor writes against a bench memory model.
    for (int i = 0; i < 256; i++) model_vld[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 255);
      d   = $urandom;
      model_mem[idx] = d;
      model_vld[idx] = 1'b1;
      dmem_write(32'(idx) << 2, d);
    end
    for (int i = 0; i < 256; i++) begin
      if (model_vld[i]) read_both("rand_rd", 32'(i) << 2, model_mem[i]);
    end

    // Reset mid-load discards the partial word and restarts at word 0.
    do_reset();
    send_word(32'hDDCC_BBAA, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset();
    send_word(32'h0403_0201, 1'b0);
    send_byte(8'h05, 1'b1);
    expect_run("reload");
    read_both("reload_mem0", 32'h0, 32'h0403_0201);
    read_both("reload_mem1", 32'h4, 32'h0000_0005);

    // Pointer wrap: 257 words, the last lands back on word 0.
    do_reset();
    for (int i = 0; i < 256; i++) send_word(32'h5A00_0000 | 32'(i), 1'b0);
    send_word(32'hCAFE_F00D, 1'b1);
    expect_run("wrap");
    read_both("wrap_mem0",   32'h0,   32'hCAFE_F00D);
    read_both("wrap_mem1",   32'h4,   32'h5A00_0001);
    read_both("wrap_mem255", 32'h3FC, 32'h5A00_00FF);
`ifdef PROC_MEM_RESP_ERR_EN
    @(negedge clk);
    check("wrap_err", {31'b0, err}, 32'd1);
    tick();

    // Out-of-range RUN address raises a sticky err.
    do_reset();
    send_byte(8'h01, 1'b1);
    expect_run("err_prog");
    @(negedge clk);
    check("err_before", {31'b0, err}, 32'd0);
    tick();
    read_both("oor_alias", 32'h0000_0400, 32'h0000_0001);
    @(negedge clk);
    check("err_set", {31'b0, err}, 32'd1);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("err_sticky", {31'b0, err}, 32'd1);
    tick();
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
